// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEFAULT_ADDR_WIDTH = 64;
    localparam int DEFAULT_DATA_WIDTH = 64;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_pos;

    // Sum is one bit wider than the index so the wrap compare cannot overflow.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(N)) begin
                w_sum = w_sum - (IDXW+1)'(N);
            end
            w_pos = w_sum[IDXW-1:0];
            if (!o_valid && i_req[w_pos]) begin
                o_valid      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency memory port between NUM_REQ requesters,
// with bounded per-requester locking and response routing back to the issuing requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_LOCK   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0]                lock_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    output logic [DATA_WIDTH-1:0]             mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           mem_be_o,
    input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEW  = DATA_WIDTH / 8;
    localparam int CNTW = (MAX_LOCK == 0) ? 8 : $clog2(MAX_LOCK + 1);

    arb_state_e          r_state;
    logic [IDXW-1:0]     r_rr_ptr;
    logic [IDXW-1:0]     r_owner;
    logic [CNTW-1:0]     r_lock_cnt;
    logic                r_resp_valid;
    logic [IDXW-1:0]     r_resp_id;

    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDXW-1:0]     w_gnt_idx;
    logic [IDXW-1:0]     w_next_gnt;
    logic [IDXW-1:0]     w_next_owner;
    logic                w_gnt_any;
    logic                w_lock_gnt;
    logic                w_owner_req;
    logic                w_owner_lock;
    logic                w_cap;

    // While locked only the owner may win; everyone else sees gnt=0.
    assign w_owner_oh   = NUM_REQ'(1) << r_owner;
    assign w_elig       = (r_state == LOCKED) ? (req_i & w_owner_oh) : req_i;
    assign w_owner_req  = |(req_i & w_owner_oh);
    assign w_owner_lock = |(lock_i & w_owner_oh);

    rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_any)
    );

    assign gnt_o        = w_gnt;
    assign mem_req_o    = w_gnt_any;
    assign w_lock_gnt   = |(lock_i & w_gnt);
    assign w_next_gnt   = IDXW'(rr_next(32'(w_gnt_idx), 32'(NUM_REQ)));
    assign w_next_owner = IDXW'(rr_next(32'(r_owner), 32'(NUM_REQ)));
    assign w_cap        = (MAX_LOCK != 0) && ((32'(r_lock_cnt) + 32'd1) == 32'(MAX_LOCK));

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                mem_we_o    = we_i[i];
                mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                mem_be_o    = be_i[i*BEW +: BEW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        if (w_lock_gnt && (MAX_LOCK != 1)) begin
                            r_state    <= LOCKED;
                            r_owner    <= w_gnt_idx;
                            r_lock_cnt <= CNTW'(1);
                        end else begin
                            r_rr_ptr <= w_next_gnt;
                        end
                    end
                end
                LOCKED: begin
                    if (w_gnt_any) begin
                        if (!w_lock_gnt || w_cap) begin
                            r_state    <= IDLE;
                            r_rr_ptr   <= w_next_owner;
                            r_lock_cnt <= '0;
                        end else if ((MAX_LOCK != 0) || (r_lock_cnt != '1)) begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end else if (!w_owner_req && !w_owner_lock) begin
                        r_state    <= IDLE;
                        r_rr_ptr   <= w_next_owner;
                        r_lock_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Every granted beat, read or write, produces exactly one response next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            r_resp_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_resp_id <= w_gnt_idx;
            end
        end
    end

    assign rvalid_o = r_resp_valid ? (NUM_REQ'(1) << r_resp_id) : '0;
    assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM on the memory port.
module tb_mem_port_arbiter;

    logic          clk = 1'b0;
    logic          rstN;
    logic [1:0]    req, lock, we;
    logic [127:0]  addrFlat, wdataFlat;
    logic [15:0]   beFlat;
    logic [1:0]    gnt, rvalid;
    logic [63:0]   rdata, memAddr, memWdata, memRdata;
    logic          memReq, memWe;
    logic [7:0]    memBe;
    logic [63:0]   ram [0:15];
    logic [1:0]    expGnt, prevGnt;
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MAX_LOCK   (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addrFlat),
        .wdata_i     (wdataFlat),
        .be_i        (beFlat),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_req_o   (memReq),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_be_o    (memBe),
        .mem_rdata_i (memRdata)
    );

    // Test RAM: byte-masked writes, reads return one cycle after the request.
    always @(posedge clk) begin
        if (memReq) begin
            if (memWe) begin
                for (int b = 0; b < 8; b++) begin
                    if (memBe[b]) ram[memAddr[6:3]][b*8 +: 8] <= memWdata[b*8 +: 8];
                end
            end else begin
                memRdata <= ram[memAddr[6:3]];
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] lockV,
                                 input logic [1:0] weV, input logic [63:0] a0, input logic [63:0] a1);
        @(posedge clk);
        #1;
        req      = reqV;
        lock     = lockV;
        we       = weV;
        addrFlat = {a1, a0};
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        req       = '0;
        lock      = '0;
        we        = '0;
        addrFlat  = '0;
        wdataFlat = '0;
        beFlat    = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[1] = 64'h0123456789ABCDEF;
        ram[2] = 64'hCAFEF00D11223344;

        @(negedge clk);
        checkOutput("reset gnt", 64'(gnt), 64'h0);
        checkOutput("reset rvalid", 64'(rvalid), 64'h0);
        checkOutput("reset mem_req", 64'(memReq), 64'h0);
        checkOutput("reset mem_addr", memAddr, 64'h0);
        #2 rstN = 1'b1;

        $display("[TB] single read by requester 0");
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h8, 64'h0);
        checkOutput("rd gnt", 64'(gnt), 64'h1);
        checkOutput("rd mem_req", 64'(memReq), 64'h1);
        checkOutput("rd mem_addr", memAddr, 64'h8);
        checkOutput("rd mem_we", 64'(memWe), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("rd rvalid", 64'(rvalid), 64'h1);
        checkOutput("rd rdata", rdata, 64'h0123456789ABCDEF);
        checkOutput("rd idle gnt", 64'(gnt), 64'h0);
        checkOutput("rd idle mem_req", 64'(memReq), 64'h0);
        checkOutput("rd idle mem_addr", memAddr, 64'h0);

        $display("[TB] partial write by requester 1");
        wdataFlat = {64'h00000000DEADBEEF, 64'h5555555555555555};
        beFlat    = {8'h0F, 8'hFF};
        applyStimulus(2'b10, 2'b00, 2'b10, 64'h0, 64'h10);
        checkOutput("wr gnt", 64'(gnt), 64'h2);
        checkOutput("wr mem_we", 64'(memWe), 64'h1);
        checkOutput("wr mem_be", 64'(memBe), 64'h0F);
        checkOutput("wr mem_addr", memAddr, 64'h10);
        checkOutput("wr mem_wdata", memWdata, 64'h00000000DEADBEEF);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("wr rvalid", 64'(rvalid), 64'h2);
        we = 2'b00;

        $display("[TB] round robin, both requesting");
        prevGnt = 2'b00;
        for (int i = 0; i < 4; i++) begin
            expGnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus(2'b11, 2'b00, 2'b00, 64'h8, 64'h18);
            checkOutput($sformatf("rr gnt %0d", i), 64'(gnt), 64'(expGnt));
            checkOutput($sformatf("rr rvalid %0d", i), 64'(rvalid), 64'(prevGnt));
            checkOutput($sformatf("rr mem_addr %0d", i), memAddr, (i % 2 == 0) ? 64'h8 : 64'h18);
            prevGnt = expGnt;
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("rr last rvalid", 64'(rvalid), 64'h2);

        $display("[TB] requester 0 locks for four beats");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, (i < 3) ? 2'b01 : 2'b00, 2'b00, 64'h8, 64'h18);
            checkOutput($sformatf("lock gnt %0d", i), 64'(gnt), 64'h1);
            checkOutput($sformatf("lock rvalid %0d", i), 64'(rvalid), (i == 0) ? 64'h0 : 64'h1);
        end
        applyStimulus(2'b11, 2'b00, 2'b00, 64'h8, 64'h18);
        checkOutput("lock after gnt", 64'(gnt), 64'h2);
        checkOutput("lock after rvalid", 64'(rvalid), 64'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("lock idle rvalid", 64'(rvalid), 64'h2);

        $display("[TB] lock held forever hits the 16-beat cap");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b11, 2'b01, 2'b00, 64'h8, 64'h18);
            checkOutput($sformatf("cap gnt %0d", i), 64'(gnt), 64'h1);
        end
        applyStimulus(2'b11, 2'b01, 2'b00, 64'h8, 64'h18);
        checkOutput("cap release gnt", 64'(gnt), 64'h2);
        checkOutput("cap release rvalid", 64'(rvalid), 64'h1);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("cap idle rvalid", 64'(rvalid), 64'h2);
        checkOutput("cap idle gnt", 64'(gnt), 64'h0);

        $display("[TB] read back partial write");
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h10, 64'h0);
        checkOutput("rb gnt", 64'(gnt), 64'h1);
        checkOutput("rb mem_addr", memAddr, 64'h10);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("rb rvalid", 64'(rvalid), 64'h1);
        checkOutput("rb rdata", rdata, 64'hCAFEF00DDEADBEEF);
        checkOutput("rb rdata low", 64'(rdata[31:0]), 64'hDEADBEEF);

        $display("[TB] reset right after a grant");
        applyStimulus(2'b01, 2'b00, 2'b00, 64'h8, 64'h0);
        checkOutput("rst pre gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        req  = 2'b00;
        @(negedge clk);
        checkOutput("rst rvalid", 64'(rvalid), 64'h0);
        checkOutput("rst mem_req", 64'(memReq), 64'h0);
        #2 rstN = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00, 64'h8, 64'h18);
        checkOutput("rst post gnt", 64'(gnt), 64'h1);
        checkOutput("rst post rvalid", 64'(rvalid), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
        checkOutput("rst post resp", 64'(rvalid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory request port (req/we/addr/wdata/be, 1-cycle read latency) of the test RAM / axi2mem-side memory between NUM_REQ requesters, e.g. CGRA AXI master, debug, loader.
- Round-robin arbitration, with an optional per-requester lock for back-to-back beats.
- Lock duration is bounded by a fairness counter.
- Routes the one-cycle-delayed response (rvalid/rdata) back to the requester that issued the beat.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, data width; byte enables DATA_WIDTH/8
MAX_LOCK, 16, max granted beats per lock tenure; 0 = unlimited

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester request
lock_i  in  NUM_REQ  requester wants to keep the port after this beat
we_i  in  NUM_REQ  write enable per requester
addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at slice i
wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data
be_i  in  NUM_REQ*DATA_WIDTH/8  flattened byte enables
gnt_o  out  NUM_REQ  one-hot grant, same cycle as request
rvalid_o  out  NUM_REQ  one-hot response valid, 1 cycle after grant (reads and writes)
rdata_o  out  DATA_WIDTH  read data, broadcast; valid where rvalid_o set
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_rdata_i  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_req_o

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0, lock_cnt=0, rvalid_o=0.
  - gnt_o and mem_req_o are 0 whenever req_i=0.
  - Reset assertion mid-transfer drops any pending response; no rvalid_o in the following cycle.
- Grant is combinational. Exactly one gnt_o bit is set if any eligible req_i is set, else 0.
  - mem_req_o = |gnt_o.
  - mem_* fields are muxed from the granted slice; they are 0 when there is no grant.
- State IDLE: eligible = all requesters. Winner = first set req_i at or after rr_ptr, wrapping modulo NUM_REQ.
  - On a grant to i with lock_i[i]=0: rr_ptr <= (i+1) mod NUM_REQ; stay IDLE.
  - On a grant to i with lock_i[i]=1 and MAX_LOCK != 1: go to LOCKED, owner <= i, lock_cnt <= 1.
  - With MAX_LOCK=1, a lock is treated as an unlocked beat.
- State LOCKED: only owner is eligible; other requests wait with gnt=0.
  - Granted owner beat with lock_i=1: lock_cnt++.
  - When lock_cnt+1 == MAX_LOCK on a granted beat (MAX_LOCK != 0): forced release. Go to IDLE with rr_ptr <= owner+1; this beat is still granted.
  - Owner beat granted with lock_i=0: final beat; go to IDLE with rr_ptr <= owner+1.
  - Owner deasserts both req and lock: go to IDLE next cycle with rr_ptr <= owner+1; no grant that cycle.
  - Owner holds lock with req=0: port idles and lock_cnt holds.
  - Other requesters are arbitrated from the cycle after the return to IDLE.
- Response path: registered resp_valid and resp_id, captured on every grant.
  - Next cycle: rvalid_o[resp_id]=1 and rdata_o=mem_rdata_i.
  - Back-to-back grants give back-to-back rvalid, one per cycle, in grant order.
- lock_cnt width is $clog2(MAX_LOCK+1); it saturates when MAX_LOCK=0 (unlimited).
- Requester contract: hold req/we/addr/wdata/be stable until gnt. The arbiter does not check this.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_e {IDLE, LOCKED}
  - default-width localparams (ADDR 64, DATA 64)
  - function rr_next(idx, n)
- Sub-module rr_pick:
  - Combinational: inputs req vector and pointer; outputs one-hot winner and index.
  - Instantiated once, with req masked to the owner when LOCKED.

Test Plan:
- Single requester 0 reads addr 0x8, RAM[1]=0x0123456789ABCDEF -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o=0x0123456789ABCDEF.
- Both request unlocked continuously, rr_ptr=0 -> grants 01,10,01,10; each rvalid follows its grant by 1 cycle with matching id.
- Req0 locks for 4 beats (lock_i high for 3, low on 4th) while req1 requests -> gnt 01 x4, then 10; req1 waits exactly 4 cycles.
- MAX_LOCK=16, req0 holds lock forever, req1 requesting -> 16 grants to req0, forced release, then req1 granted next cycle.
- Req1 write 0xDEADBEEF to 0x10 with be=0x0F, then req0 reads 0x10 -> mem_be_o=0x0F on the write; read returns lower 32 bits 0xDEADBEEF.
- rst_ni pulsed low the cycle after a grant -> rvalid_o stays 0; state IDLE, rr_ptr=0; first post-reset grant goes to req0 when both request.
